// File: rtl/conv_pkg.sv
// Shared convolver definitions: parameter defaults, window element indexing and the
// fill/stream state encoding used by the line buffer, weight register and multiplier.
package conv_pkg;

    localparam int DATA_WIDTH_DEFAULT  = 16;
    localparam int KERNEL_SIZE_DEFAULT = 5;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Flat position of window element (r,c); r=0 is the top row, c=k-1 the newest column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// One image row of delay: a DEPTH-deep shift register advanced only when i_en is high,
// so o_dout is the sample pushed DEPTH enables ago (same column, previous row).
module line_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28
) (
    input  logic                         clk,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_din,
    output logic signed [DATA_WIDTH-1:0] o_dout
);

    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/window_line_buffer.sv
// Raster-order pixel stream to KERNEL_SIZE x KERNEL_SIZE sliding windows via chained line FIFOs.
// Build option WINDOW_STRIDE2_EN: emit only windows whose offset from the first position is even in both axes.
module window_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
    parameter int KERNEL_SIZE  = KERNEL_SIZE_DEFAULT,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic signed [DATA_WIDTH-1:0]               pixel_in,
    input  logic                                       pixel_in_valid,
    output logic                                       pixel_in_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
    output logic                                       window_valid,
    input  logic                                       window_ready,
    output logic                                       frame_done
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic KM1_ODD = 1'((KERNEL_SIZE - 1) % 2);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic                         r_window_valid;
    logic                         r_frame_done;
    logic                         w_accept;
    logic                         w_row_end;
    logic                         w_frame_end;
    logic                         w_pos_ok;
    logic                         w_emit;
    logic signed [DATA_WIDTH-1:0] w_tap    [KERNEL_SIZE-1];
    logic signed [DATA_WIDTH-1:0] w_newcol [KERNEL_SIZE];
    logic signed [DATA_WIDTH-1:0] r_win    [KERNEL_SIZE][KERNEL_SIZE];

    assign pixel_in_ready = !r_window_valid || window_ready;
    assign w_accept       = pixel_in_valid && pixel_in_ready;
    assign w_row_end      = (r_col == CW'(IMAGE_WIDTH - 1));
    assign w_frame_end    = w_row_end && (r_row == RW'(IMAGE_HEIGHT - 1));

`ifdef WINDOW_STRIDE2_EN
    assign w_pos_ok = (r_col >= CW'(KERNEL_SIZE - 1)) &&
                      (r_col[0] == KM1_ODD) && (r_row[0] == KM1_ODD);
`else
    assign w_pos_ok = (r_col >= CW'(KERNEL_SIZE - 1));
`endif

    assign w_emit = w_accept && (r_state == S_STREAM) && w_pos_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:   if (w_accept && w_row_end && (r_row == RW'(KERNEL_SIZE - 2))) w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && w_frame_end) w_state_nxt = S_FILL;
            default:  w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col          <= '0;
            r_row          <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done   <= w_accept && w_frame_end;
            r_window_valid <= w_emit || (r_window_valid && !window_ready);
            if (w_accept) begin
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= w_frame_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Tap g holds the pixel g+1 rows above the incoming one.
    for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_line
        if (g == 0) begin : g_first
            line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_fifo (
                .clk    (clk),
                .i_en   (w_accept),
                .i_din  (pixel_in),
                .o_dout (w_tap[g])
            );
        end else begin : g_chain
            line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_fifo (
                .clk    (clk),
                .i_en   (w_accept),
                .i_din  (w_tap[g-1]),
                .o_dout (w_tap[g])
            );
        end
        assign w_newcol[g] = w_tap[KERNEL_SIZE-2-g];
    end
    assign w_newcol[KERNEL_SIZE-1] = pixel_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][KERNEL_SIZE-1] <= w_newcol[r];
            end
        end
    end

    for (genvar gr = 0; gr < KERNEL_SIZE; gr++) begin : g_row
        for (genvar gc = 0; gc < KERNEL_SIZE; gc++) begin : g_col
            localparam int IDX = win_idx(gr, gc, KERNEL_SIZE);
            assign window_out[IDX*DATA_WIDTH +: DATA_WIDTH] = r_win[gr][gc];
        end
    end

    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_line_buffer.sv
// Self-checking bench for window_line_buffer (K=3, W=6, H=5) against a frame-array window model.
module tb_window_line_buffer;

    localparam int K  = 3;
    localparam int W  = 6;
    localparam int H  = 5;
    localparam int DW = 16;
    localparam int WW = K * K * DW;
`ifdef WINDOW_STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int EXP_WIN = ((H - K + STEP) / STEP) * ((W - K + STEP) / STEP);

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] pixel_in;
    logic                 pixel_in_valid;
    logic                 pixel_in_ready;
    logic [WW-1:0]        window_out;
    logic                 window_valid;
    logic                 window_ready;
    logic                 frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] frame_pix [W*H];
    logic [WW-1:0] gold [$];
    logic [WW-1:0] cap  [$];
    int            acc_cnt = 0;
    int            fd_cnt  = 0;
    int            fd_acc  = -1;
    int            first_win_n;
    logic [WW-1:0] first_win;

    window_line_buffer #(
        .DATA_WIDTH   (DW),
        .KERNEL_SIZE  (K),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_ready (pixel_in_ready),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .window_ready   (window_ready),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Observe handshakes mid-cycle; each negedge precedes exactly one rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (window_valid && window_ready) cap.push_back(window_out);
                if (frame_done) begin
                    fd_cnt++;
                    fd_acc = acc_cnt;
                end
                if (pixel_in_valid && pixel_in_ready) acc_cnt++;
            end
        end
    end

    task automatic set_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame_pix[r*W + c] = 16'(r * 16 + c);
    endtask

    task automatic set_random();
        for (int i = 0; i < W*H; i++) frame_pix[i] = 16'($urandom);
    endtask

    // Every KxK block whose bottom-right lands on the stride grid, in raster order.
    task automatic build_gold();
        logic [WW-1:0] w;
        gold.delete();
        for (int row = K - 1; row < H; row += STEP) begin
            for (int col = K - 1; col < W; col += STEP) begin
                w = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w[(r*K + c)*DW +: DW] = frame_pix[(row - K + 1 + r)*W + (col - K + 1 + c)];
                gold.push_back(w);
            end
        end
    endtask

    task automatic drive_frame(input int npix, input int gap, input bit rnd_rdy, input bit do_stall);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        bit seen = 0;
        logic [WW-1:0] snap;
        first_win_n = -1;
        while (n < npix && cyc < 4000) begin
            if (do_stall && window_valid && !stalled) begin
                stalled = 1;
                snap = window_out;
                window_ready = 1'b0;
                pixel_in_valid = 1'b1;
                pixel_in = frame_pix[n];
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (pixel_in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall_ready cycle %0d got %b exp 0", s, pixel_in_ready);
                    end
                    n_cmp++;
                    if (window_out !== snap || window_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_hold cycle %0d got %h/%b exp %h/1", s, window_out, window_valid, snap);
                    end
                    @(posedge clk); #1;
                end
                window_ready = 1'b1;
            end
            pixel_in_valid = ($urandom_range(99) >= gap);
            pixel_in = frame_pix[n];
            if (rnd_rdy) window_ready = 1'($urandom_range(1));
            @(negedge clk);
            if (window_valid && !seen) begin
                seen = 1;
                first_win_n = n;
                first_win = window_out;
            end
            if (pixel_in_valid && pixel_in_ready) n++;
            @(posedge clk); #1;
            cyc++;
        end
        pixel_in_valid = 1'b0;
        window_ready = 1'b1;
        n_cmp++;
        if (n != npix) begin
            n_bad++;
            $display("FAIL drive_timeout accepted %0d exp %0d", n, npix);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pixel_in = '0;
        pixel_in_valid = 1'b0;
        window_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (window_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b fd=%b w=%h exp 0/0/0", window_valid, frame_done, window_out);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pixel_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b exp 1", pixel_in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first_window();
        logic [WW-1:0] exp_w;
        set_pattern();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                exp_w[(r*K + c)*DW +: DW] = 16'(r * 16 + c);
        drive_frame(W*H, 0, 1'b0, 1'b0);
        n_cmp++;
        if (first_win_n != 15) begin
            n_bad++;
            $display("FAIL first_latency got %0d accepts exp 15", first_win_n);
        end
        n_cmp++;
        if (first_win !== exp_w) begin
            n_bad++;
            $display("FAIL first_window got %h exp %h", first_win, exp_w);
        end
    endtask

    task automatic test_full_frame();
        int base = cap.size();
        int bfd = fd_cnt;
        int bacc = acc_cnt;
        logic [DW-1:0] tl;
        set_pattern();
        build_gold();
        drive_frame(W*H, 0, 1'b0, 1'b0);
        n_cmp++;
        if (cap.size() - base != EXP_WIN || gold.size() != EXP_WIN) begin
            n_bad++;
            $display("FAIL full_count got %0d exp %0d", cap.size() - base, EXP_WIN);
        end
        for (int i = 0; i < gold.size() && base + i < cap.size(); i++) begin
            n_cmp++;
            if (cap[base + i] !== gold[i]) begin
                n_bad++;
                $display("FAIL full_win[%0d] got %h exp %h", i, cap[base + i], gold[i]);
            end
        end
        tl = cap[cap.size() - 1][DW-1:0];
        n_cmp++;
`ifdef WINDOW_STRIDE2_EN
        if (tl !== 16'd34) begin
`else
        if (tl !== 16'd35) begin
`endif
            n_bad++;
            $display("FAIL last_topleft got %0d", tl);
        end
        n_cmp++;
        if (fd_cnt - bfd != 1 || fd_acc - bacc != W*H) begin
            n_bad++;
            $display("FAIL frame_done pulses %0d at accept %0d exp 1 at %0d", fd_cnt - bfd, fd_acc - bacc, W*H);
        end
    endtask

    task automatic test_stall();
        int base = cap.size();
        set_pattern();
        build_gold();
        drive_frame(W*H, 0, 1'b0, 1'b1);
        n_cmp++;
        if (cap.size() - base != gold.size()) begin
            n_bad++;
            $display("FAIL stall_count got %0d exp %0d", cap.size() - base, gold.size());
        end
        for (int i = 0; i < gold.size() && base + i < cap.size(); i++) begin
            n_cmp++;
            if (cap[base + i] !== gold[i]) begin
                n_bad++;
                $display("FAIL stall_win[%0d] got %h exp %h", i, cap[base + i], gold[i]);
            end
        end
    endtask

    task automatic test_random_flow(input bit rnd_data);
        int base = cap.size();
        int bfd = fd_cnt;
        if (rnd_data) set_random();
        else set_pattern();
        build_gold();
        drive_frame(W*H, 50, 1'b1, 1'b0);
        n_cmp++;
        if (cap.size() - base != gold.size() || fd_cnt - bfd != 1) begin
            n_bad++;
            $display("FAIL rand_count got %0d/%0d exp %0d/1", cap.size() - base, fd_cnt - bfd, gold.size());
        end
        for (int i = 0; i < gold.size() && base + i < cap.size(); i++) begin
            n_cmp++;
            if (cap[base + i] !== gold[i]) begin
                n_bad++;
                $display("FAIL rand%0d_win[%0d] got %h exp %h", rnd_data, i, cap[base + i], gold[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        set_random();
        drive_frame(20, 0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (window_valid !== 1'b0 || window_out !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear got v=%b w=%h exp 0", window_valid, window_out);
        end
        @(posedge clk); #1;
        base = cap.size();
        set_pattern();
        build_gold();
        drive_frame(W*H, 0, 1'b0, 1'b0);
        n_cmp++;
        if (first_win_n != 15 || cap.size() - base != gold.size()) begin
            n_bad++;
            $display("FAIL midreset_restart latency %0d count %0d exp 15/%0d", first_win_n, cap.size() - base, gold.size());
        end
        for (int i = 0; i < gold.size() && base + i < cap.size(); i++) begin
            n_cmp++;
            if (cap[base + i] !== gold[i]) begin
                n_bad++;
                $display("FAIL midreset_win[%0d] got %h exp %h", i, cap[base + i], gold[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_full_frame();
        test_stall();
        test_random_flow(1'b0);
        test_random_flow(1'b1);
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
